// File: rtl/xadc_oversample_multi_if.sv
// Sample/result bundle between the XADC sequencer wrapper and the oversampler.
// The wrapper side drives sample/eoc/channel/clear; the oversampler returns
// the decimated result with its channel tag and a one-cycle done strobe.
interface xadc_oversample_multi_if #(
    parameter int SAMPLE_W = 12,
    parameter int CH_W     = 2,
    parameter int OUT_W    = 16
);
    logic [SAMPLE_W-1:0] sample;
    logic                eoc;
    logic [CH_W-1:0]     channel;
    logic                clear;
    logic [OUT_W-1:0]    oversample;
    logic [CH_W-1:0]     out_channel;
    logic                done;

    modport master (
        output sample, eoc, channel, clear,
        input  oversample, out_channel, done
    );

    modport slave (
        input  sample, eoc, channel, clear,
        output oversample, out_channel, done
    );
endinterface

// File: rtl/xadc_oversample_multi.sv
// Multi-channel oversampler/decimator. Each channel owns an accumulator and a
// sample counter; after 2**LOG2_N accepted samples the channel's sum is
// rounded (half up) down to SAMPLE_W+EXTRA_BITS bits and presented with a
// one-cycle done pulse. Results hold until the next completed block.
module xadc_oversample_multi #(
    parameter int SAMPLE_W   = 12,
    parameter int NUM_CH     = 4,
    parameter int LOG2_N     = 8,
    parameter int EXTRA_BITS = 4
) (
    input logic                     clk,
    input logic                     reset,
    xadc_oversample_multi_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = SAMPLE_W + LOG2_N;
    localparam int SHIFT = LOG2_N - EXTRA_BITS;
    localparam int OUT_W = SAMPLE_W + EXTRA_BITS;

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    // Half-LSB of the output; zero when no bits are dropped.
    localparam logic [ACC_W-1:0] RND =
        (SHIFT > 0) ? (ACC_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [LOG2_N-1:0] cnt [NUM_CH];

    logic [OUT_W-1:0]  oversample_q;
    logic [CH_W-1:0]   out_channel_q;
    logic              done_q;

    logic              ch_ok;
    logic              accept;
    logic              last;
    logic [ACC_W-1:0]  total;
    logic [ACC_W-1:0]  total_rnd;
    logic [OUT_W-1:0]  rounded;

    // Decode the incoming sample: accept it, form the running total and the
    // rounded result used when this sample closes the channel's block.
    always_comb begin
        ch_ok     = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        total     = '0;
        total_rnd = '0;
        rounded   = '0;
        ch_ok     = (32'(bus.channel) < NUM_CH);
        // clear takes priority over a coincident sample
        accept    = bus.eoc && ch_ok && !bus.clear;
        if (ch_ok) begin
            last  = (cnt[bus.channel] == CNT_LAST);
            total = acc[bus.channel] + ACC_W'(bus.sample);
        end
        // Cannot overflow: the full-scale sum leaves 2**LOG2_N - 1 of headroom
        // and RND is at most half of 2**LOG2_N.
        total_rnd = total + RND;
        rounded   = OUT_W'(total_rnd >> SHIFT);
    end

    // Per-channel accumulation, block completion and held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            oversample_q  <= '0;
            out_channel_q <= '0;
            done_q        <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    acc[c] <= '0;
                    cnt[c] <= '0;
                end
            end else if (accept) begin
                if (last) begin
                    acc[bus.channel] <= '0;
                    cnt[bus.channel] <= '0;
                    oversample_q     <= rounded;
                    out_channel_q    <= bus.channel;
                    done_q           <= 1'b1;
                end else begin
                    acc[bus.channel] <= total;
                    cnt[bus.channel] <= cnt[bus.channel] + 1'b1;
                end
            end
        end
    end

    assign bus.oversample  = oversample_q;
    assign bus.out_channel = out_channel_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_xadc_oversample_multi.sv
// Bench for the oversampler: a 4-channel build and a 3-channel build share the
// same stimulus. A reference model computes each expected result (with the
// cycle it must appear) and queues it; per-DUT monitors check done, the
// result and the held outputs every cycle.
module tb_xadc_oversample_multi;
    localparam int SAMPLE_W   = 12;
    localparam int LOG2_N     = 4;
    localparam int EXTRA_BITS = 2;
    localparam int CH_W       = 2;
    localparam int OUT_W      = SAMPLE_W + EXTRA_BITS;
    localparam int SHIFT      = LOG2_N - EXTRA_BITS;
    localparam int BLK        = 1 << LOG2_N;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xadc_oversample_multi_if #(.SAMPLE_W(SAMPLE_W), .CH_W(CH_W), .OUT_W(OUT_W)) bus4 ();
    xadc_oversample_multi_if #(.SAMPLE_W(SAMPLE_W), .CH_W(CH_W), .OUT_W(OUT_W)) bus3 ();

    xadc_oversample_multi #(.SAMPLE_W(SAMPLE_W), .NUM_CH(4), .LOG2_N(LOG2_N),
                            .EXTRA_BITS(EXTRA_BITS))
        dut4 (.clk(clk), .reset(reset), .bus(bus4));

    xadc_oversample_multi #(.SAMPLE_W(SAMPLE_W), .NUM_CH(3), .LOG2_N(LOG2_N),
                            .EXTRA_BITS(EXTRA_BITS))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        int due;
        bit is_rst;
        int ch;
        int val;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   acc_m [2][4];
    int   cnt_m [2][4];
    int   hold_v [2];
    int   hold_c [2];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q4.push_back(e);
        else        q3.push_back(e);
    endtask

    // Reference: sum BLK samples per channel, round half up, drop SHIFT bits.
    task automatic model(input int d, input bit r, input bit clr, input bit e,
                         input int ch, input int s);
        exp_t x;
        if (r || clr) begin
            for (int c = 0; c < 4; c++) begin
                acc_m[d][c] = 0;
                cnt_m[d][c] = 0;
            end
            if (r) begin
                x = '{due: cyc + 1, is_rst: 1'b1, ch: 0, val: 0};
                push(d, x);
            end
        end else if (e && ch < nch(d)) begin
            acc_m[d][ch] += s;
            cnt_m[d][ch] += 1;
            if (cnt_m[d][ch] == BLK) begin
                x = '{due: cyc + 1, is_rst: 1'b0, ch: ch,
                      val: (acc_m[d][ch] + ((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0)) >> SHIFT};
                push(d, x);
                acc_m[d][ch] = 0;
                cnt_m[d][ch] = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit clr, input bit e, input int ch, input int s);
        reset        = r;
        bus4.clear   = clr;
        bus4.eoc     = e;
        bus4.channel = CH_W'(ch);
        bus4.sample  = SAMPLE_W'(s);
        bus3.clear   = clr;
        bus3.eoc     = e;
        bus3.channel = CH_W'(ch);
        bus3.sample  = SAMPLE_W'(s);
        model(0, r, clr, e, ch, s);
        model(1, r, clr, e, ch, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input int d, input logic dn, input logic [OUT_W-1:0] os,
                       input logic [CH_W-1:0] oc);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0 && q4.size() > 0 && q4[0].due == cyc) begin
            e = q4.pop_front();
            have = 1'b1;
        end else if (d == 1 && q3.size() > 0 && q3[0].due == cyc) begin
            e = q3.pop_front();
            have = 1'b1;
        end
        if (have && e.is_rst) begin
            hold_v[d] = 0;
            hold_c[d] = 0;
            have = 1'b0;
        end else if (have) begin
            hold_v[d] = e.val;
            hold_c[d] = e.ch;
        end
        n_checks++;
        if (dn !== have) begin
            n_fail++;
            $display("FAIL done dut%0d cyc=%0d: got %b want %b", d, cyc, dn, have);
        end
        n_checks++;
        if (os !== OUT_W'(hold_v[d])) begin
            n_fail++;
            $display("FAIL oversample dut%0d cyc=%0d: got 0x%0h want 0x%0h",
                     d, cyc, os, hold_v[d]);
        end
        n_checks++;
        if (oc !== CH_W'(hold_c[d])) begin
            n_fail++;
            $display("FAIL out_channel dut%0d cyc=%0d: got %0d want %0d",
                     d, cyc, oc, hold_c[d]);
        end
    endtask

    // Monitors: compare each DUT's outputs every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk(0, bus4.done, bus4.oversample, bus4.out_channel);
            chk(1, bus3.done, bus3.oversample, bus3.out_channel);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            hold_v[d] = 0;
            hold_c[d] = 0;
            for (int c = 0; c < 4; c++) begin
                acc_m[d][c] = 0;
                cnt_m[d][c] = 0;
            end
        end

        repeat (3) step(1, 0, 0, 0, 0);
        idle(2);

        // full-scale midpoint on ch0
        for (int i = 0; i < BLK; i++) step(0, 0, 1, 0, 12'h800);
        idle(2);

        // rounding edges and maximum on ch1
        for (int i = 0; i < BLK - 1; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 2);
        for (int i = 0; i < BLK - 1; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        for (int i = 0; i < BLK; i++) step(0, 0, 1, 1, 12'hFFF);
        idle(2);

        // round-robin over all channels
        for (int r = 0; r < BLK; r++)
            for (int k = 0; k < 4; k++) step(0, 0, 1, k, 12'h100 * (k + 1));
        idle(2);

        // partial block, clear with a coincident sample, then a fresh block
        for (int i = 0; i < 8; i++) step(0, 0, 1, 2, 12'h123);
        step(0, 1, 1, 2, 12'h7FF);
        for (int i = 0; i < BLK; i++) step(0, 0, 1, 2, 12'h010);
        idle(2);

        // channel 3 is out of range for the 3-channel build
        for (int i = 0; i < BLK; i++) begin
            step(0, 0, 1, 3, 12'hABC);
            step(0, 0, 1, 0, 12'h020);
        end
        idle(2);

        // reset mid-block, then a clean block
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 12'h3FF);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 12'h555);
        for (int i = 0; i < BLK; i++) step(0, 0, 1, 0, 12'h004);
        idle(2);

        // done scheduled on the cycle before a clear must still pulse
        for (int i = 0; i < BLK; i++) step(0, 0, 1, 1, 12'h040);
        step(0, 1, 0, 0, 0);
        idle(2);

        // random interleave
        for (int i = 0; i < 10000; i++) begin
            int gap;
            int s;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (gap > 0) idle(gap);
            s = ($urandom_range(0, 7) == 0) ? 12'hFFF : int'($urandom_range(0, 4095));
            if ($urandom_range(0, 1999) == 0)
                step(1, 0, 1, int'($urandom_range(0, 3)), s);
            else if ($urandom_range(0, 299) == 0)
                step(0, 1, 1, int'($urandom_range(0, 3)), s);
            else
                step(0, 0, 1, int'($urandom_range(0, 3)), s);
        end
        idle(4);

        n_checks++;
        if (q4.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending results dut4=%0d dut3=%0d want 0",
                     q4.size(), q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
